// File: rtl/shift_reg_piso_tx.sv
// Parallel-in, serial-out transmitter: accepts a word on a valid/ready handshake
// and shifts it out one bit per clock with frame_start/done strobes.
module shift_reg_piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             active;
    logic             last_bit;
    logic             accept;
    logic             head_bit;

    assign active   = (state == SHIFT);
    assign last_bit = active && (cnt == LAST);
    assign accept   = load_valid && load_ready;
    assign head_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            // A word arriving on the last bit chains straight into a new frame.
            state <= SHIFT;
            shreg <= din;
            cnt   <= '0;
        end else if (active) begin
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            if (cnt == LAST) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Outputs come from registered state only; reset gates them low immediately.
    assign load_ready  = !reset && (!active || last_bit);
    assign sdo         = !reset && active && head_bit;
    assign sdo_valid   = !reset && active;
    assign frame_start = !reset && active && (cnt == '0);
    assign done        = !reset && last_bit;

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Directed bench for shift_reg_piso_tx: three configurations (4/MSB, 4/LSB, 8/MSB)
// exercised through a vector table plus hand-written multi-cycle sequences.
module tb_shift_reg_piso_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] din;
    logic       lv;
    int         sel;

    logic lr_m, sdo_m, sv_m, fs_m, dn_m;
    logic lr_l, sdo_l, sv_l, fs_l, dn_l;
    logic lr_w, sdo_w, sv_w, fs_w, dn_w;
    logic o_lr, o_sdo, o_sv, o_fs, o_dn;

    int checks   = 0;
    int failures = 0;

    shift_reg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m (
        .clk(clk), .reset(reset), .din(din[3:0]), .load_valid(lv && sel == 0),
        .load_ready(lr_m), .sdo(sdo_m), .sdo_valid(sv_m), .frame_start(fs_m), .done(dn_m)
    );
    shift_reg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l (
        .clk(clk), .reset(reset), .din(din[3:0]), .load_valid(lv && sel == 1),
        .load_ready(lr_l), .sdo(sdo_l), .sdo_valid(sv_l), .frame_start(fs_l), .done(dn_l)
    );
    shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w (
        .clk(clk), .reset(reset), .din(din), .load_valid(lv && sel == 2),
        .load_ready(lr_w), .sdo(sdo_w), .sdo_valid(sv_w), .frame_start(fs_w), .done(dn_w)
    );

    always_comb begin
        o_lr = 1'b0; o_sdo = 1'b0; o_sv = 1'b0; o_fs = 1'b0; o_dn = 1'b0;
        case (sel)
            0:       begin o_lr = lr_m; o_sdo = sdo_m; o_sv = sv_m; o_fs = fs_m; o_dn = dn_m; end
            1:       begin o_lr = lr_l; o_sdo = sdo_l; o_sv = sv_l; o_fs = fs_l; o_dn = dn_l; end
            default: begin o_lr = lr_w; o_sdo = sdo_w; o_sv = sv_w; o_fs = fs_w; o_dn = dn_w; end
        endcase
    end

    // exp holds the transmitted bits in order, first bit at exp[width-1].
    typedef struct {
        int         sel;
        int         width;
        logic [7:0] din;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input int s, input int w, input logic [7:0] d,
                             input logic [7:0] e, input string nm);
        sel = s;
        din = d;
        lv  = 1'b1;
        check({nm, " ready_idle"}, 32'(o_lr), 32'd1);
        step();
        lv  = 1'b0;
        din = ~d;
        for (int k = 0; k < w; k++) begin
            check($sformatf("%s sdo[%0d]", nm, k), 32'(o_sdo), 32'(e[w-1-k]));
            check($sformatf("%s valid[%0d]", nm, k), 32'(o_sv), 32'd1);
            check($sformatf("%s start[%0d]", nm, k), 32'(o_fs), 32'(k == 0));
            check($sformatf("%s done[%0d]", nm, k), 32'(o_dn), 32'(k == w - 1));
            check($sformatf("%s ready[%0d]", nm, k), 32'(o_lr), 32'(k == w - 1));
            if (k < w - 1) step();
        end
        step();
        check({nm, " idle_sdo"}, 32'(o_sdo), 32'd0);
        check({nm, " idle_valid"}, 32'(o_sv), 32'd0);
        check({nm, " idle_ready"}, 32'(o_lr), 32'd1);
    endtask

    initial begin
        logic [7:0] b2b_exp;
        logic [3:0] c_exp;

        vecs[0] = '{0, 4, 8'h0B, 8'h0B, "m4_1011"};
        vecs[1] = '{1, 4, 8'h0B, 8'h0D, "l4_1011"};
        vecs[2] = '{0, 4, 8'h06, 8'h06, "m4_0110"};
        vecs[3] = '{1, 4, 8'h01, 8'h08, "l4_0001"};
        vecs[4] = '{2, 8, 8'hA5, 8'hA5, "m8_a5"};
        vecs[5] = '{2, 8, 8'h81, 8'h81, "m8_81"};

        reset = 1'b1; din = 8'hFF; lv = 1'b1; sel = 0;
        step(); step();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            check($sformatf("rst%0d ready", s), 32'(o_lr), 32'd0);
            check($sformatf("rst%0d sdo", s), 32'(o_sdo), 32'd0);
            check($sformatf("rst%0d valid", s), 32'(o_sv), 32'd0);
            check($sformatf("rst%0d start", s), 32'(o_fs), 32'd0);
            check($sformatf("rst%0d done", s), 32'(o_dn), 32'd0);
        end
        lv = 1'b0; sel = 0;
        reset = 1'b0;
        step();
        check("post_rst valid", 32'(o_sv), 32'd0);

        foreach (vecs[i]) run_frame(vecs[i].sel, vecs[i].width, vecs[i].din, vecs[i].exp, vecs[i].name);

        // Back-to-back: A then 5 offered on the done cycle, no gap.
        b2b_exp = 8'b1010_0101;
        sel = 0; din = 8'h0A; lv = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            if (k >= 3) din = 8'h05;
            if (k == 7) lv = 1'b0;
            check($sformatf("b2b sdo[%0d]", k), 32'(o_sdo), 32'(b2b_exp[7-k]));
            check($sformatf("b2b valid[%0d]", k), 32'(o_sv), 32'd1);
            check($sformatf("b2b start[%0d]", k), 32'(o_fs), 32'(k == 0 || k == 4));
            check($sformatf("b2b done[%0d]", k), 32'(o_dn), 32'(k == 3 || k == 7));
            check($sformatf("b2b ready[%0d]", k), 32'(o_lr), 32'(k == 3 || k == 7));
            step();
        end
        check("b2b idle_valid", 32'(o_sv), 32'd0);

        // Mid-frame load attempt is ignored.
        din = 8'h0F; lv = 1'b1;
        step();
        lv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin lv = 1'b1; din = 8'h00; end
            if (k == 2) lv = 1'b0;
            if (k == 1) check("mid ready", 32'(o_lr), 32'd0);
            check($sformatf("mid sdo[%0d]", k), 32'(o_sdo), 32'd1);
            check($sformatf("mid valid[%0d]", k), 32'(o_sv), 32'd1);
            step();
        end
        check("mid idle_valid", 32'(o_sv), 32'd0);

        // Reset on bit 2 of C aborts the frame; reset wins over a coincident load.
        c_exp = 4'b1100;
        din = 8'h0C; lv = 1'b1;
        step();
        lv = 1'b0;
        check("abort sdo[0]", 32'(o_sdo), 32'(c_exp[3]));
        step();
        reset = 1'b1; lv = 1'b1; din = 8'h03;
        #0;
        check("abort rst_sdo", 32'(o_sdo), 32'd0);
        check("abort rst_valid", 32'(o_sv), 32'd0);
        check("abort rst_ready", 32'(o_lr), 32'd0);
        step();
        reset = 1'b0; lv = 1'b0;
        #0;
        check("abort after_valid", 32'(o_sv), 32'd0);
        check("abort after_done", 32'(o_dn), 32'd0);
        check("abort after_sdo", 32'(o_sdo), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("abort quiet_done[%0d]", k), 32'(o_dn), 32'd0);
            check($sformatf("abort quiet_valid[%0d]", k), 32'(o_sv), 32'd0);
        end
        run_frame(0, 4, 8'h03, 8'h03, "after_rst_3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
